// File: rtl/delay_seq_checker.sv
// rtl/delay_seq_checker.sv - hardware checker for "a followed by b exactly DELAY cycles later"
//
// Every sampled a_i starts an attempt that is carried through a DELAY-deep
// shift register. When an attempt reaches the top bit it is judged against the
// b_i sample on that edge, producing a one-cycle match_o or fail_o pulse.
// Attempts may overlap freely (one started and one judged per cycle).
//
// Ports:
//   clk_i          rising-edge clock
//   rst_i          asynchronous active-high reset
//   clr_i          synchronous clear of attempt history, pulses and counters
//   a_i            start event
//   b_i            completion event
//   match_o        registered pulse: an attempt matured with b_i high
//   fail_o         registered pulse: an attempt matured with b_i low
//   busy_o         at least one attempt in flight
//   match_count_o  saturating count of matches
//   fail_count_o   saturating count of fails
module delay_seq_checker #(
  parameter int DELAY = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             a_i,
  input  logic             b_i,
  output logic             match_o,
  output logic             fail_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] match_count_o,
  output logic [CNT_W-1:0] fail_count_o
);

  generate
    if (DELAY < 1 || DELAY > 16) begin : g_bad_delay
      $error("delay_seq_checker: DELAY must be in 1..16");
    end
    if (CNT_W < 2 || CNT_W > 32) begin : g_bad_cnt_w
      $error("delay_seq_checker: CNT_W must be in 2..32");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [DELAY-1:0] hist_q, hist_d;
  logic             match_q, match_d;
  logic             fail_q, fail_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic             mat;

  // Oldest history bit is the attempt that was started DELAY edges ago.
  assign mat = hist_q[DELAY-1];

  // A single-stage history has nothing to shift; it simply reloads from a_i.
  generate
    if (DELAY == 1) begin : g_shift_one
      assign hist_d = a_i;
    end else begin : g_shift_many
      assign hist_d = {hist_q[DELAY-2:0], a_i};
    end
  endgenerate

  always_comb begin
    match_d     = mat & b_i;
    fail_d      = mat & ~b_i;
    match_cnt_d = match_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    // Counters stick at all-ones; pulses keep firing regardless.
    if (match_d && match_cnt_q != CNT_MAX) begin
      match_cnt_d = match_cnt_q + CNT_W'(1);
    end
    if (fail_d && fail_cnt_q != CNT_MAX) begin
      fail_cnt_d = fail_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hist_q      <= '0;
      match_q     <= 1'b0;
      fail_q      <= 1'b0;
      match_cnt_q <= '0;
      fail_cnt_q  <= '0;
    end else if (clr_i) begin
      // Drops both the incoming a_i and any attempt maturing on this edge.
      hist_q      <= '0;
      match_q     <= 1'b0;
      fail_q      <= 1'b0;
      match_cnt_q <= '0;
      fail_cnt_q  <= '0;
    end else begin
      hist_q      <= hist_d;
      match_q     <= match_d;
      fail_q      <= fail_d;
      match_cnt_q <= match_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
    end
  end

  assign match_o       = match_q;
  assign fail_o        = fail_q;
  assign busy_o        = |hist_q;
  assign match_count_o = match_cnt_q;
  assign fail_count_o  = fail_cnt_q;

endmodule

// File: tb/tb_delay_seq_checker.sv
// tb/tb_delay_seq_checker.sv - directed bench for delay_seq_checker
module tb_delay_seq_checker;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;
  logic a   = 1'b0;
  logic b   = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  logic       m1, f1, y1;
  logic [7:0] mc1, fc1;
  logic       m3, f3, y3;
  logic [7:0] mc3, fc3;
  logic       m2, f2, y2;
  logic [7:0] mc2, fc2;
  logic       ms, fs, ys;
  logic [1:0] mcs, fcs;

  delay_seq_checker #(.DELAY(1), .CNT_W(8)) u_d1 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .a_i(a), .b_i(b),
    .match_o(m1), .fail_o(f1), .busy_o(y1), .match_count_o(mc1), .fail_count_o(fc1));
  delay_seq_checker #(.DELAY(3), .CNT_W(8)) u_d3 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .a_i(a), .b_i(b),
    .match_o(m3), .fail_o(f3), .busy_o(y3), .match_count_o(mc3), .fail_count_o(fc3));
  delay_seq_checker #(.DELAY(2), .CNT_W(8)) u_d2 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .a_i(a), .b_i(b),
    .match_o(m2), .fail_o(f2), .busy_o(y2), .match_count_o(mc2), .fail_count_o(fc2));
  delay_seq_checker #(.DELAY(2), .CNT_W(2)) u_sat (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .a_i(a), .b_i(b),
    .match_o(ms), .fail_o(fs), .busy_o(ys), .match_count_o(mcs), .fail_count_o(fcs));

  typedef struct {
    logic       rs;   // reset all instances before this row
    logic       a;
    logic       b;
    logic       clr;
    logic       m;
    logic       f;
    logic       busy;
    logic [7:0] mc;
    logic [7:0] fc;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Leaves the bench at a falling edge with rst released; the next rising
  // edge is edge 1.
  task automatic do_reset();
    @(negedge clk);
    a = 1'b0; b = 1'b0; clr = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive inputs, take one rising edge, sample just after it.
  task automatic step(input logic ia, input logic ib, input logic iclr);
    a = ia; b = ib; clr = iclr;
    @(posedge clk);
    #1;
  endtask

  int pulses;
  int matured;

  initial begin
    // DELAY=3 overlap: a at edges 1-4, b at edges 4 and 6
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1, 8'd0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1, 8'd1};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2, 8'd1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2, 8'd2};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 8'd2};
    // DELAY=3 single fail: a at edge 5, b never
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd1};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1};

    // Reset state, checked while rst is held
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_match", 32'(m3), 32'd0);
    chk("rst_fail", 32'(f3), 32'd0);
    chk("rst_busy", 32'(y3), 32'd0);
    chk("rst_mc", 32'(mc3), 32'd0);
    chk("rst_fc", 32'(fc3), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      if (tbl[i].rs) do_reset();
      step(tbl[i].a, tbl[i].b, tbl[i].clr);
      chk($sformatf("vec%0d_match", i), 32'(m3), 32'(tbl[i].m));
      chk($sformatf("vec%0d_fail", i), 32'(f3), 32'(tbl[i].f));
      chk($sformatf("vec%0d_busy", i), 32'(y3), 32'(tbl[i].busy));
      chk($sformatf("vec%0d_mc", i), 32'(mc3), 32'(tbl[i].mc));
      chk($sformatf("vec%0d_fc", i), 32'(fc3), 32'(tbl[i].fc));
    end

    // DELAY=1: a at edge 2, b at edge 3
    do_reset();
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("d1_e2_busy", 32'(y1), 32'd1);
    chk("d1_e2_match", 32'(m1), 32'd0);
    step(1'b0, 1'b1, 1'b0);
    chk("d1_e3_match", 32'(m1), 32'd1);
    chk("d1_e3_mc", 32'(mc1), 32'd1);
    chk("d1_e3_busy", 32'(y1), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    chk("d1_e4_match", 32'(m1), 32'd0);
    chk("d1_e4_mc", 32'(mc1), 32'd1);
    chk("d1_e4_fc", 32'(fc1), 32'd0);

    // Saturation, DELAY=2 CNT_W=2: six matching attempts at edges 1-6
    do_reset();
    pulses = 0;
    for (int e = 1; e <= 10; e++) begin
      step(e <= 6, 1'b1, 1'b0);
      matured = (e < 3) ? 0 : ((e > 8) ? 6 : e - 2);
      if (ms) pulses++;
      chk($sformatf("sat_e%0d_mc", e), 32'(mcs), 32'((matured > 3) ? 3 : matured));
      chk($sformatf("sat_e%0d_fail", e), 32'(fs), 32'd0);
    end
    chk("sat_pulses", 32'(pulses), 32'd6);

    // Asynchronous reset mid-cycle with two attempts in flight (DELAY=3)
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("arst_busy_before", 32'(y3), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(y3), 32'd0);
    chk("arst_match", 32'(m3), 32'd0);
    chk("arst_fail", 32'(f3), 32'd0);
    chk("arst_mc", 32'(mc3), 32'd0);
    chk("arst_fc", 32'(fc3), 32'd0);
    #1;
    rst = 1'b0;
    pulses = 0;
    for (int e = 0; e < 5; e++) begin
      step(1'b0, 1'b0, 1'b0);
      if (f3) pulses++;
    end
    chk("arst_no_fail", 32'(pulses), 32'd0);
    chk("arst_fc_after", 32'(fc3), 32'd0);

    // clr on maturing edge, DELAY=2: build counts 5/1, a at 10, clr at 12
    do_reset();
    for (int e = 1; e <= 11; e++) begin
      step((e <= 6) || (e == 10), (e >= 3) && (e <= 7), 1'b0);
    end
    chk("clr_pre_mc", 32'(mc2), 32'd5);
    chk("clr_pre_fc", 32'(fc2), 32'd1);
    chk("clr_pre_busy", 32'(y2), 32'd1);
    step(1'b1, 1'b1, 1'b1);
    chk("clr_mc", 32'(mc2), 32'd0);
    chk("clr_fc", 32'(fc2), 32'd0);
    chk("clr_match", 32'(m2), 32'd0);
    chk("clr_fail", 32'(f2), 32'd0);
    chk("clr_busy", 32'(y2), 32'd0);
    pulses = 0;
    for (int e = 0; e < 3; e++) begin
      step(1'b0, 1'b0, 1'b0);
      if (m2 || f2) pulses++;
    end
    chk("clr_a_discarded", 32'(pulses), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
